// File: rtl/rst_seq_ctrl_pkg.sv
// Shared definitions for the reset sequencer: state encoding, default timing
// constants, and the per-channel release threshold helper.
package rst_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_STAGE   = 3'd1,
    ST_RUN     = 3'd2,
    ST_DONE    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_e;

  localparam int unsigned DEF_N_CH     = 3;
  localparam int unsigned DEF_HOLD_CYC = 25;
  localparam int unsigned DEF_STAGGER  = 4;
  localparam int unsigned DEF_CNT_W    = 32;
  localparam int unsigned SYNC_STAGES  = 2;

  // The synchroniser latency is part of the hold window, so the hold can never be shorter than it.
  function automatic int unsigned eff_hold(input int unsigned hold);
    return (hold < SYNC_STAGES) ? SYNC_STAGES : hold;
  endfunction

  // Stage-counter value at which channel k is released.
  function automatic int unsigned rel_thresh(input int unsigned hold, input int unsigned stagger,
                                             input int unsigned k);
    return eff_hold(hold) - SYNC_STAGES + k * stagger;
  endfunction

endpackage

// File: rtl/rst_seq_ctrl_rst_sync.sv
// Two-flop reset synchroniser: asynchronous assert, synchronous deassert.
// A synchronous set input lets a soft reset restart the same release latency.
module rst_seq_ctrl_rst_sync (
  input  logic i_clk,
  input  logic i_arst,
  input  logic i_srst,
  output logic o_rst
);

  logic [1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      r_sync <= 2'b11;
    end else if (i_srst) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], 1'b0};
    end
  end

  assign o_rst = r_sync[1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// Staged per-domain reset sequencer with run-cycle counter, halt latch and watchdog.
// Channel k is released HOLD_CYC + k*STAGGER + 1 edges after rst_in (or soft_rst_in) drops.
module rst_seq_ctrl
  import rst_seq_ctrl_pkg::*;
#(
  parameter int unsigned     N_CH     = DEF_N_CH,
  parameter int unsigned     HOLD_CYC = DEF_HOLD_CYC,
  parameter int unsigned     STAGGER  = DEF_STAGGER,
  parameter int unsigned     CNT_W    = DEF_CNT_W,
  parameter longint unsigned TIMEOUT  = 64'd0
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             soft_rst_in,
  input  logic             pause_in,
  input  logic             halt_in,
  output logic [N_CH-1:0]  ch_rst_out,
  output logic             rdy_out,
  output logic             running_out,
  output logic             done_out,
  output logic             timeout_out,
  output logic [CNT_W-1:0] cyc_cnt_out
);

  localparam int unsigned HOLD_EFF = eff_hold(HOLD_CYC);
  localparam int unsigned STG_W    = $clog2(HOLD_EFF + N_CH * STAGGER + 2);
  localparam int unsigned CW1      = CNT_W + 1;
  localparam logic        WD_EN    = (TIMEOUT != 64'd0);

  state_e           r_state;
  logic [STG_W-1:0] r_stg;
  logic [N_CH-1:0]  r_ch;
  logic             r_rdy;
  logic             r_running;
  logic             r_done;
  logic             r_timeout;
  logic [CNT_W-1:0] r_cyc;

  logic             w_sync_rst;
  logic [N_CH-1:0]  w_keep;
  logic [CNT_W:0]   w_cyc_inc;
  logic [CNT_W-1:0] w_cyc_sat;
  logic             w_wd_hit;

  rst_seq_ctrl_rst_sync u_rst_sync (
    .i_clk  (clk_in),
    .i_arst (rst_in),
    .i_srst (soft_rst_in),
    .o_rst  (w_sync_rst)
  );

  // Per-channel hold mask: a bit stays set until the stage counter reaches its threshold.
  for (genvar k = 0; k < N_CH; k++) begin : g_keep
    localparam int unsigned THR = rel_thresh(HOLD_CYC, STAGGER, k);
    assign w_keep[k] = (r_stg < STG_W'(THR));
  end

  // Saturating run counter; the watchdog compares against the pre-increment value + 1.
  assign w_cyc_inc = {1'b0, r_cyc} + CW1'(1);
  assign w_cyc_sat = w_cyc_inc[CNT_W] ? r_cyc : w_cyc_inc[CNT_W-1:0];
  assign w_wd_hit  = WD_EN && (w_cyc_inc == CW1'(TIMEOUT));

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state   <= ST_HOLD;
      r_stg     <= '0;
      r_ch      <= '1;
      r_rdy     <= 1'b0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_cyc     <= '0;
    end else if (soft_rst_in || w_sync_rst) begin
      r_state   <= ST_HOLD;
      r_stg     <= '0;
      r_ch      <= '1;
      r_rdy     <= 1'b0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_cyc     <= '0;
    end else begin
      case (r_state)
        ST_HOLD: begin
          r_stg <= r_stg + STG_W'(1);
          r_ch  <= r_ch & w_keep;
          if (!w_keep[0]) r_state <= ST_STAGE;
        end
        ST_STAGE: begin
          if (r_ch == '0) begin
            r_state   <= ST_RUN;
            r_rdy     <= !pause_in;
            r_running <= 1'b1;
          end else begin
            r_stg <= r_stg + STG_W'(1);
            r_ch  <= r_ch & w_keep;
          end
        end
        ST_RUN: begin
          r_cyc <= w_cyc_sat;
          // Halt outranks a watchdog expiry landing on the same edge.
          if (halt_in) begin
            r_state   <= ST_DONE;
            r_done    <= 1'b1;
            r_rdy     <= 1'b0;
            r_running <= 1'b0;
          end else if (w_wd_hit) begin
            r_state   <= ST_TIMEOUT;
            r_timeout <= 1'b1;
            r_rdy     <= 1'b0;
            r_running <= 1'b0;
          end else begin
            r_rdy <= !pause_in;
          end
        end
        default: ;
      endcase
    end
  end

  assign ch_rst_out  = r_ch;
  assign rdy_out     = r_rdy;
  assign running_out = r_running;
  assign done_out    = r_done;
  assign timeout_out = r_timeout;
  assign cyc_cnt_out = r_cyc;

endmodule
